// File: rtl/sc_sync_pkg.sv
// Shared types and helpers for the Schmidl-Cox frame-sync controller.
package sc_sync_pkg;

    localparam int SC_CNT_W = 16;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        RUN    = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } sc_state_e;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] maxv;
        maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sc_skid_buf.sv
// Two-entry AXI-Stream register slice; in_ready_o is registered so it never
// depends combinationally on out_ready_i.
module sc_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] out_q, skid_q;
    logic         out_vld_q, skid_vld_q;

    assign in_ready_o  = ~skid_vld_q;
    assign out_data_o  = out_q;
    assign out_valid_o = out_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (flush_i) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (out_ready_i || !out_vld_q) begin
            if (skid_vld_q) begin
                out_q      <= skid_q;
                out_vld_q  <= 1'b1;
                skid_vld_q <= 1'b0;
            end else begin
                out_q     <= in_data_i;
                out_vld_q <= in_valid_i;
            end
        end else if (in_valid_i && !skid_vld_q) begin
            skid_q     <= in_data_i;
            skid_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/schmidl_cox_sync_ctrl.sv
// Frame-sync controller: finds a metric plateau above threshold, skips an
// offset, then forwards one frame of samples with a generated tlast.
module schmidl_cox_sync_ctrl
    import sc_sync_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int METRIC_W = 32,
    parameter int CNT_W    = SC_CNT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                cfg_enable,
    input  logic [METRIC_W-1:0] cfg_threshold,
    input  logic [CNT_W-1:0]    cfg_min_run,
    input  logic [CNT_W-1:0]    cfg_offset,
    input  logic [CNT_W-1:0]    cfg_frame_len,
    input  logic [DATA_W-1:0]   i_tdata,
    input  logic                i_tlast,
    input  logic                i_tvalid,
    output logic                i_tready,
    input  logic [METRIC_W-1:0] metric_tdata,
    input  logic                metric_tlast,
    input  logic                metric_tvalid,
    output logic                metric_tready,
    output logic [DATA_W-1:0]   o_tdata,
    output logic                o_tlast,
    output logic                o_tvalid,
    input  logic                o_tready,
    output logic                det_pulse,
    output logic [METRIC_W-1:0] det_peak,
    output logic [CNT_W-1:0]    det_peak_dist,
    output logic [CNT_W-1:0]    frame_count,
    output logic                busy
);

    sc_state_e             state_q, state_d;
    logic [CNT_W-1:0]      run_cnt_q, run_cnt_d, peak_idx_q, peak_idx_d;
    logic [CNT_W-1:0]      off_cnt_q, off_cnt_d, out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]      min_run_q, min_run_d, offset_q, offset_d, flen_q, flen_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d, det_dist_q, det_dist_d;
    logic [METRIC_W-1:0]   thr_q, thr_d, peak_q, peak_d, det_peak_q, det_peak_d;
    logic                  det_pulse_q, det_pulse_d;
    logic                  skid_rdy, can_take, take, fwd_valid, fwd_last;
    logic                  unused_tlast;

    assign unused_tlast = i_tlast ^ metric_tlast;

    // A zero-offset detection forwards the plateau-ending beat, so that beat
    // must also wait for room in the slice.
    assign can_take      = (state_q == OUTPUT || (state_q == RUN && offset_q == '0)) ? skid_rdy : 1'b1;
    assign take          = i_tvalid & metric_tvalid & can_take;
    assign i_tready      = metric_tvalid & can_take;
    assign metric_tready = i_tvalid & can_take;

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        peak_d      = peak_q;
        peak_idx_d  = peak_idx_q;
        off_cnt_d   = off_cnt_q;
        out_cnt_d   = out_cnt_q;
        thr_d       = thr_q;
        min_run_d   = min_run_q;
        offset_d    = offset_q;
        flen_d      = flen_q;
        frame_cnt_d = frame_cnt_q;
        det_peak_d  = det_peak_q;
        det_dist_d  = det_dist_q;
        det_pulse_d = 1'b0;
        fwd_valid   = 1'b0;
        fwd_last    = 1'b0;
        case (state_q)
            SEARCH: if (take && cfg_enable && metric_tdata > cfg_threshold) begin
                state_d    = RUN;
                run_cnt_d  = CNT_W'(1);
                peak_d     = metric_tdata;
                peak_idx_d = '0;
                out_cnt_d  = '0;
                thr_d      = cfg_threshold;
                min_run_d  = (cfg_min_run == '0) ? CNT_W'(1) : cfg_min_run;
                offset_d   = cfg_offset;
                flen_d     = cfg_frame_len;
            end
            RUN: if (take) begin
                if (metric_tdata > thr_q) begin
                    run_cnt_d = CNT_W'(sat_inc(32'(run_cnt_q), CNT_W));
                    if (metric_tdata > peak_q) begin
                        peak_d     = metric_tdata;
                        peak_idx_d = run_cnt_q;
                    end
                end else if (run_cnt_q < min_run_q) begin
                    state_d = SEARCH;
                end else begin
                    det_pulse_d = 1'b1;
                    det_peak_d  = peak_q;
                    det_dist_d  = run_cnt_q - CNT_W'(1) - peak_idx_q;
                    off_cnt_d   = CNT_W'(1);
                    if (flen_q == '0)
                        state_d = SEARCH;
                    else if (offset_q == '0) begin
                        state_d   = OUTPUT;
                        fwd_valid = 1'b1;
                    end else if (offset_q == CNT_W'(1))
                        state_d = OUTPUT;
                    else
                        state_d = WAIT;
                end
            end
            WAIT: if (take) begin
                off_cnt_d = off_cnt_q + CNT_W'(1);
                if (off_cnt_d == offset_q) state_d = OUTPUT;
            end
            OUTPUT: fwd_valid = take;
            default: state_d = SEARCH;
        endcase
        if (fwd_valid) begin
            fwd_last  = (out_cnt_q == flen_q - CNT_W'(1));
            out_cnt_d = out_cnt_q + CNT_W'(1);
            if (fwd_last) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                state_d     = SEARCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEARCH;
            run_cnt_q   <= '0;
            peak_q      <= '0;
            peak_idx_q  <= '0;
            off_cnt_q   <= '0;
            out_cnt_q   <= '0;
            thr_q       <= '0;
            min_run_q   <= '0;
            offset_q    <= '0;
            flen_q      <= '0;
            frame_cnt_q <= '0;
            det_peak_q  <= '0;
            det_dist_q  <= '0;
            det_pulse_q <= 1'b0;
        end else if (clear) begin
            state_q     <= SEARCH;
            run_cnt_q   <= '0;
            peak_q      <= '0;
            peak_idx_q  <= '0;
            off_cnt_q   <= '0;
            out_cnt_q   <= '0;
            thr_q       <= '0;
            min_run_q   <= '0;
            offset_q    <= '0;
            flen_q      <= '0;
            frame_cnt_q <= '0;
            det_peak_q  <= '0;
            det_dist_q  <= '0;
            det_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            peak_q      <= peak_d;
            peak_idx_q  <= peak_idx_d;
            off_cnt_q   <= off_cnt_d;
            out_cnt_q   <= out_cnt_d;
            thr_q       <= thr_d;
            min_run_q   <= min_run_d;
            offset_q    <= offset_d;
            flen_q      <= flen_d;
            frame_cnt_q <= frame_cnt_d;
            det_peak_q  <= det_peak_d;
            det_dist_q  <= det_dist_d;
            det_pulse_q <= det_pulse_d;
        end
    end

    sc_skid_buf #(.W(DATA_W + 1)) u_skid (
        .clk         (clk),
        .rst_n       (reset_n),
        .flush_i     (clear),
        .in_data_i   ({fwd_last, i_tdata}),
        .in_valid_i  (fwd_valid),
        .in_ready_o  (skid_rdy),
        .out_data_o  ({o_tlast, o_tdata}),
        .out_valid_o (o_tvalid),
        .out_ready_i (o_tready)
    );

    assign det_pulse     = det_pulse_q;
    assign det_peak      = det_peak_q;
    assign det_peak_dist = det_dist_q;
    assign frame_count   = frame_cnt_q;
    assign busy          = (state_q != SEARCH);

endmodule
